coupler_stream_arbiter: RTL and testbench

- Shares one coupler between N requester FIFOs (e.g. merger-tree leaves).
- Grants one requester at a time, round-robin, at stream granularity. A stream ends with an all-zero terminator word.
- Forwards granted head word to the coupler input FIFO (i_data/i_enq/o_full side), so 2-word pairs never mix streams.

---
 rtl/coupler_stream_arbiter_pkg.sv | 24 ++
 rtl/coupler_stream_arbiter_rr_priority_pick.sv | 29 ++
 rtl/coupler_stream_arbiter.sv | 159 +++++++++++++++
 tb/tb_coupler_stream_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coupler_stream_arbiter_pkg.sv
// Shared definitions for the coupler stream arbiter: FSM state encoding,
// the stream terminator word and a constant-width helper.
package coupler_stream_arbiter_pkg;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StStream = 1'b1
  } state_e;

  // Widest word the terminator constant covers; callers slice it to P_WIDTH.
  localparam int unsigned MaxWidth = 1024;
  localparam logic [MaxWidth-1:0] Terminator = '0;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((64'd1 << width) < 64'(value)) begin
      width++;
    end
    return width;
  endfunction

endpackage

// File: rtl/coupler_stream_arbiter_rr_priority_pick.sv
// Round-robin priority pick: first set bit of req at or above start,
// wrapping from N_REQ-1 back to 0. Purely combinational.
module rr_priority_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_start,
  output logic             o_found,
  output logic [ID_W-1:0]  o_idx
);

  logic [ID_W-1:0] cand;

  // Scan farthest-first so the candidate closest to start is written last.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    cand    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ID_W'((32'(i_start) + 32'(i)) % N_REQ);
      if (i_req[cand]) begin
        o_found = 1'b1;
        o_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/coupler_stream_arbiter.sv
// Shares one coupler between N_REQ requester FIFOs, granting whole streams
// round-robin. A stream ends with an all-zero word; words are forwarded with
// zero latency so a coupler word pair never mixes two streams.
// Optional stall watchdog: define COUPLER_ARB_WATCHDOG_EN.
module coupler_stream_arbiter
  import coupler_stream_arbiter_pkg::*;
#(
  parameter int unsigned P_WIDTH = 512,
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ID_W    = 2
`ifdef COUPLER_ARB_WATCHDOG_EN
  ,
  parameter int unsigned WD_CYCLES = 1024
`endif
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ*P_WIDTH-1:0] i_req_data,
  input  logic [N_REQ-1:0]         i_req_empty,
  output logic [N_REQ-1:0]         o_req_deq,
  output logic [P_WIDTH-1:0]       o_data,
  output logic                     o_enq,
  input  logic                     i_full,
  output logic [ID_W-1:0]          o_grant_id,
  output logic                     o_busy,
  output logic                     o_stream_done,
  output logic                     o_pair_phase
`ifdef COUPLER_ARB_WATCHDOG_EN
  ,
  output logic                     o_wd_abort
`endif
);

  state_e          state_q, state_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic [ID_W-1:0] rr_q, rr_d;
  logic            phase_q, phase_d;
  logic            done_q, done_d;

  logic [P_WIDTH-1:0] head;
  logic               head_empty;
  logic               xfer;
  logic               inject;
  logic               term;
  logic               pick_found;
  logic [ID_W-1:0]    pick_idx;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .i_req   (~i_req_empty),
    .i_start (rr_q),
    .o_found (pick_found),
    .o_idx   (pick_idx)
  );

  assign head       = i_req_data[grant_q*P_WIDTH +: P_WIDTH];
  assign head_empty = i_req_empty[grant_q];
  // Strobes are suppressed while reset is held so nothing leaks into the coupler.
  assign xfer       = (state_q == StStream) & ~head_empty & ~i_full & ~i_rst;
  assign term       = (xfer & (head == Terminator[P_WIDTH-1:0])) | inject;

`ifdef COUPLER_ARB_WATCHDOG_EN
  localparam int unsigned WdW = clog2(WD_CYCLES + 1);

  logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
  logic           wd_expired;
  logic           abort_q;

  assign wd_expired = (wd_cnt_q == WdW'(WD_CYCLES));
  // A requester that refills in time wins over the injected terminator.
  assign inject     = (state_q == StStream) & wd_expired & ~xfer & ~i_full & ~i_rst;
  assign o_wd_abort = abort_q;

  // Count consecutive empty-head cycles of the granted stream, saturating.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (xfer || inject || (state_q != StStream)) begin
      wd_cnt_d = '0;
    end else if (head_empty && !wd_expired) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  // Watchdog counter and abort pulse registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wd_cnt_q <= '0;
      abort_q  <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      abort_q  <= inject;
    end
  end
`else
  assign inject = 1'b0;
`endif

  // Coupler and requester strobes; data is forwarded straight from the granted head.
  always_comb begin
    o_req_deq          = '0;
    o_req_deq[grant_q] = xfer;
    o_enq              = xfer | inject;
    o_data             = inject ? '0 : head;
  end

  // Arbitration in IDLE, stream tracking and pair phase in STREAM.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    phase_d = phase_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d = pick_idx;
          rr_d    = (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
          state_d = StStream;
        end
      end
      StStream: begin
        if (term) begin
          // Zero either pads the pair (phase 0) or completes it (phase 1).
          phase_d = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (xfer) begin
          phase_d = ~phase_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; a reset abandons any open stream.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      rr_q    <= '0;
      phase_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      phase_q <= phase_d;
      done_q  <= done_d;
    end
  end

  assign o_grant_id    = grant_q;
  assign o_busy        = (state_q == StStream);
  assign o_stream_done = done_q;
  assign o_pair_phase  = phase_q;

endmodule

// File: tb/tb_coupler_stream_arbiter.sv
// Bench for coupler_stream_arbiter: directed cycle table, stall / watchdog
// sequence, then randomized traffic against a queue-based reference model.
module tb_coupler_stream_arbiter;
  localparam int unsigned W  = 16;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;
`ifdef COUPLER_ARB_WATCHDOG_EN
  localparam int unsigned WD = 8;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_empty;
  logic [N-1:0]   req_deq;
  logic [W-1:0]   data;
  logic           enq;
  logic           full;
  logic [IW-1:0]  grant;
  logic           busy;
  logic           done;
  logic           phase;
`ifdef COUPLER_ARB_WATCHDOG_EN
  logic           wd_abort;
`endif

  always #5 clk = ~clk;

  coupler_stream_arbiter #(
    .P_WIDTH (W),
    .N_REQ   (N),
    .ID_W    (IW)
`ifdef COUPLER_ARB_WATCHDOG_EN
    ,
    .WD_CYCLES (WD)
`endif
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_data    (req_data),
    .i_req_empty   (req_empty),
    .o_req_deq     (req_deq),
    .o_data        (data),
    .o_enq         (enq),
    .i_full        (full),
    .o_grant_id    (grant),
    .o_busy        (busy),
    .o_stream_done (done),
    .o_pair_phase  (phase)
`ifdef COUPLER_ARB_WATCHDOG_EN
    ,
    .o_wd_abort    (wd_abort)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs between edges, then let combinational outputs settle.
  task automatic drive(input logic r, input logic [N-1:0] e, input logic f,
                       input logic [N*W-1:0] d);
    @(negedge clk);
    rst = r; req_empty = e; full = f; req_data = d;
    #1;
  endtask

  typedef struct {
    logic           rst;
    logic [N-1:0]   empty;
    logic           full;
    logic [N*W-1:0] din;
    logic           e_enq;
    logic [N-1:0]   e_deq;
    logic           cs;
    logic [IW-1:0]  e_grant;
    logic           e_busy;
    logic           e_phase;
    logic           e_done;
    logic           cd;
    logic [W-1:0]   e_data;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic [3:0] e, input logic f,
                              input logic [W-1:0] d0, input logic [W-1:0] d1,
                              input logic [W-1:0] d2, input logic [W-1:0] d3,
                              input logic xe, input logic [3:0] xd, input logic cs,
                              input logic [1:0] xg, input logic xb, input logic xp,
                              input logic xdn, input logic cd, input logic [W-1:0] xdat);
    vec_t v;
    v.rst = r; v.empty = e; v.full = f; v.din = {d3, d2, d1, d0};
    v.e_enq = xe; v.e_deq = xd; v.cs = cs; v.e_grant = xg; v.e_busy = xb;
    v.e_phase = xp; v.e_done = xdn; v.cd = cd; v.e_data = xdat;
    tbl.push_back(v);
  endfunction

  // Reference model state (stream level: grant, rr pointer, words sent).
  logic [W-1:0] q[N][$];
  bit           m_busy = 0;
  int           m_grant = 0;
  int           m_rr = 0;
  int           m_words = 0;
  bit           m_done = 0;
  bit           m_abort = 0;
  int           m_wd = 0;

  initial begin
    logic [3:0]   e0;
    logic [3:0]   ef;
    logic [N-1:0] empty_v;
    logic [W-1:0] head_w;
    bit           exp_xfer;
    bit           exp_inj;
    bit           found;
    int           k;

    e0 = 4'b1110;
    ef = 4'hF;
    // r  e    f  d0 d1 d2 d3  enq deq  cs g b p dn cd data
    add(1, ef, 0, 0, 0, 0, 0,  0, 0,    0, 0, 0, 0, 0, 0, 0);
    add(1, ef, 0, 0, 0, 0, 0,  0, 0,    1, 0, 0, 0, 0, 0, 0);
    // Stream 5,7,9,0 from requester 0
    add(0, e0, 0, 5, 0, 0, 0,  0, 0,    1, 0, 0, 0, 0, 1, 5);
    add(0, e0, 0, 5, 0, 0, 0,  1, 1,    1, 0, 1, 0, 0, 1, 5);
    add(0, e0, 0, 7, 0, 0, 0,  1, 1,    1, 0, 1, 1, 0, 1, 7);
    add(0, e0, 0, 9, 0, 0, 0,  1, 1,    1, 0, 1, 0, 0, 1, 9);
    add(0, e0, 0, 0, 0, 0, 0,  1, 1,    1, 0, 1, 1, 0, 1, 0);
    add(0, ef, 0, 0, 0, 0, 0,  0, 0,    1, 0, 0, 0, 1, 0, 0);
    add(0, ef, 0, 0, 0, 0, 0,  0, 0,    1, 0, 0, 0, 0, 0, 0);
    // Odd stream 4,0: terminator in phase 1
    add(0, e0, 0, 4, 0, 0, 0,  0, 0,    1, 0, 0, 0, 0, 1, 4);
    add(0, e0, 0, 4, 0, 0, 0,  1, 1,    1, 0, 1, 0, 0, 1, 4);
    add(0, e0, 0, 0, 0, 0, 0,  1, 1,    1, 0, 1, 1, 0, 1, 0);
    add(0, ef, 0, 0, 0, 0, 0,  0, 0,    1, 0, 0, 0, 1, 0, 0);
    // Even stream 4,6,0: terminator in phase 0
    add(0, e0, 0, 4, 0, 0, 0,  0, 0,    1, 0, 0, 0, 0, 1, 4);
    add(0, e0, 0, 4, 0, 0, 0,  1, 1,    1, 0, 1, 0, 0, 1, 4);
    add(0, e0, 0, 6, 0, 0, 0,  1, 1,    1, 0, 1, 1, 0, 1, 6);
    add(0, e0, 0, 0, 0, 0, 0,  1, 1,    1, 0, 1, 0, 0, 1, 0);
    add(0, ef, 0, 0, 0, 0, 0,  0, 0,    1, 0, 0, 0, 1, 0, 0);
    // Full stall of 10 cycles mid-stream
    add(0, e0, 0, 5, 0, 0, 0,  0, 0,    1, 0, 0, 0, 0, 1, 5);
    add(0, e0, 0, 5, 0, 0, 0,  1, 1,    1, 0, 1, 0, 0, 1, 5);
    for (int i = 0; i < 10; i++) begin
      add(0, e0, 1, 7, 0, 0, 0, 0, 0,   1, 0, 1, 1, 0, 1, 7);
    end
    add(0, e0, 0, 7, 0, 0, 0,  1, 1,    1, 0, 1, 1, 0, 1, 7);
    add(0, e0, 0, 0, 0, 0, 0,  1, 1,    1, 0, 1, 0, 0, 1, 0);
    add(0, ef, 0, 0, 0, 0, 0,  0, 0,    1, 0, 0, 0, 1, 0, 0);
    // Reset after 2 words of requester 2's stream; rr must restart at 0
    add(0, 4'b1011, 0, 0, 0, 1, 0, 0, 0,       1, 0, 0, 0, 0, 1, 0);
    add(0, 4'b1011, 0, 0, 0, 1, 0, 1, 4'b0100, 1, 2, 1, 0, 0, 1, 1);
    add(0, 4'b1011, 0, 0, 0, 2, 0, 1, 4'b0100, 1, 2, 1, 1, 0, 1, 2);
    add(1, 4'b1011, 0, 0, 0, 3, 0, 0, 0,       1, 2, 1, 0, 0, 1, 3);
    add(0, 4'h0, 0, 16'h11, 16'h22, 16'h3, 16'h44, 0, 0, 1, 0, 0, 0, 0, 1, 16'h11);
    add(0, ef,   0, 16'h11, 16'h22, 16'h3, 16'h44, 0, 0, 1, 0, 1, 0, 0, 1, 16'h11);
    add(1, ef,   0, 16'h11, 16'h22, 16'h3, 16'h44, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    add(0, ef, 0, 0, 0, 0, 0,  0, 0,    1, 0, 0, 0, 0, 0, 0);
    // Requesters 1 and 3 contend: 1, then 3, then 1 again
    add(0, 4'b0101, 0, 0, 16'hA1, 0, 16'hB3, 0, 0,       1, 0, 0, 0, 0, 1, 0);
    add(0, 4'b0101, 0, 0, 16'hA1, 0, 16'hB3, 1, 4'b0010, 1, 1, 1, 0, 0, 1, 16'hA1);
    add(0, 4'b0101, 0, 0, 0,      0, 16'hB3, 1, 4'b0010, 1, 1, 1, 1, 0, 1, 0);
    add(0, 4'b0111, 0, 0, 0,      0, 16'hB3, 0, 0,       1, 1, 0, 0, 1, 1, 0);
    add(0, 4'b0111, 0, 0, 0,      0, 16'hB3, 1, 4'b1000, 1, 3, 1, 0, 0, 1, 16'hB3);
    add(0, 4'b0111, 0, 0, 0,      0, 0,      1, 4'b1000, 1, 3, 1, 1, 0, 1, 0);
    add(0, 4'b0101, 0, 0, 16'hC1, 0, 16'hB3, 0, 0,       1, 3, 0, 0, 1, 1, 16'hB3);
    add(0, 4'b0101, 0, 0, 16'hC1, 0, 16'hB3, 1, 4'b0010, 1, 1, 1, 0, 0, 1, 16'hC1);
    add(1, ef, 0, 0, 0, 0, 0,  0, 0,    1, 1, 1, 1, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].empty, tbl[i].full, tbl[i].din);
      chk($sformatf("row%0d enq", i), enq, tbl[i].e_enq);
      chk($sformatf("row%0d deq", i), req_deq, tbl[i].e_deq);
      if (tbl[i].cs) begin
        chk($sformatf("row%0d grant", i), grant, tbl[i].e_grant);
        chk($sformatf("row%0d busy", i), busy, tbl[i].e_busy);
        chk($sformatf("row%0d phase", i), phase, tbl[i].e_phase);
        chk($sformatf("row%0d done", i), done, tbl[i].e_done);
      end
      if (tbl[i].cd) chk($sformatf("row%0d data", i), data, tbl[i].e_data);
    end

    // Requester 0 sends one word then runs dry while requester 1 waits.
    drive(0, 4'b1110, 0, {16'h0, 16'h0, 16'h77, 16'h5});
    drive(0, 4'b1110, 0, {16'h0, 16'h0, 16'h77, 16'h5});
    chk("dry first enq", enq, 1'b1);
    chk("dry first data", data, 16'h5);
`ifdef COUPLER_ARB_WATCHDOG_EN
    for (int i = 0; i < WD; i++) begin
      drive(0, 4'b1101, 0, {16'h0, 16'h0, 16'h77, 16'h0});
      chk($sformatf("wd wait%0d enq", i), enq, 1'b0);
      chk($sformatf("wd wait%0d abort", i), wd_abort, 1'b0);
    end
    drive(0, 4'b1101, 0, {16'h0, 16'h0, 16'h77, 16'h0});
    chk("wd inject enq", enq, 1'b1);
    chk("wd inject data", data, 16'h0);
    chk("wd inject deq", req_deq, 4'b0000);
    chk("wd inject phase", phase, 1'b1);
    drive(0, 4'b1101, 0, {16'h0, 16'h0, 16'h77, 16'h0});
    chk("wd abort pulse", wd_abort, 1'b1);
    chk("wd done pulse", done, 1'b1);
    chk("wd busy", busy, 1'b0);
    chk("wd phase", phase, 1'b0);
    chk("wd idle enq", enq, 1'b0);
    drive(0, 4'b1101, 0, {16'h0, 16'h0, 16'h77, 16'h0});
    chk("wd next grant", grant, 2'd1);
    chk("wd next enq", enq, 1'b1);
    chk("wd next deq", req_deq, 4'b0010);
    chk("wd next data", data, 16'h77);
    chk("wd abort clear", wd_abort, 1'b0);
`else
    for (int i = 0; i < 20; i++) begin
      drive(0, 4'b1101, 0, {16'h0, 16'h0, 16'h77, 16'h0});
      chk($sformatf("hold%0d enq", i), enq, 1'b0);
      chk($sformatf("hold%0d grant", i), grant, 2'd0);
      chk($sformatf("hold%0d busy", i), busy, 1'b1);
    end
`endif

    // Randomized traffic against the reference model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int r = 0; r < N; r++) begin
        if (q[r].size() == 0 && $urandom_range(0, 3) == 0) begin
          int len;
          len = $urandom_range(0, 5);
          for (int j = 0; j < len; j++) q[r].push_back(W'($urandom_range(1, 16'hFFFF)));
          q[r].push_back('0);
        end
      end
      rst  = (cyc < 2) || ($urandom_range(0, 299) == 0);
      full = ($urandom_range(0, 3) == 0);
      for (int r = 0; r < N; r++) begin
        empty_v[r] = (q[r].size() == 0) || ($urandom_range(0, 4) == 0);
        req_data[r*W +: W] = (q[r].size() != 0) ? q[r][0] : W'($urandom);
      end
      req_empty = empty_v;
      #1;
      head_w   = (q[m_grant].size() != 0) ? q[m_grant][0] : '0;
      exp_xfer = !rst && m_busy && !empty_v[m_grant] && !full;
      exp_inj  = 1'b0;
`ifdef COUPLER_ARB_WATCHDOG_EN
      exp_inj  = !rst && m_busy && !exp_xfer && !full && (m_wd == WD);
`endif
      chk("rnd enq", enq, exp_xfer || exp_inj);
      chk("rnd deq", req_deq, exp_xfer ? (4'b0001 << m_grant) : 4'b0000);
      if (exp_xfer || exp_inj) chk("rnd data", data, exp_inj ? '0 : head_w);
      if (cyc > 0) begin
        chk("rnd grant", grant, m_grant);
        chk("rnd busy", busy, m_busy);
        chk("rnd phase", phase, m_words % 2);
        chk("rnd done", done, m_done);
`ifdef COUPLER_ARB_WATCHDOG_EN
        chk("rnd abort", wd_abort, m_abort);
`endif
      end
      for (int r = 0; r < N; r++) begin
        if (req_deq[r] && q[r].size() != 0) void'(q[r].pop_front());
      end
      // Advance the model across the coming clock edge.
      if (rst) begin
        m_busy = 0; m_grant = 0; m_rr = 0; m_words = 0; m_done = 0; m_abort = 0; m_wd = 0;
      end else begin
        m_done  = 0;
        m_abort = 0;
        if (!m_busy) begin
          found = 0;
          for (int i = 0; i < N; i++) begin
            k = (m_rr + i) % N;
            if (!found && !empty_v[k]) begin
              found = 1; m_grant = k; m_rr = (k + 1) % N; m_busy = 1;
            end
          end
        end else if (exp_xfer) begin
          m_wd = 0;
          if (head_w == 0) begin
            m_busy = 0; m_words = 0; m_done = 1;
          end else begin
            m_words++;
          end
        end else if (exp_inj) begin
          m_wd = 0; m_busy = 0; m_words = 0; m_done = 1; m_abort = 1;
        end else begin
`ifdef COUPLER_ARB_WATCHDOG_EN
          if (empty_v[m_grant] && m_wd < WD) m_wd++;
`endif
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
